// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the IF/DM memory port arbiter.
// State encodings and owner ids used by the arbiter and its picker.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_DM = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
// On a tie the requester that did not own the port last time wins.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic win_o,
  output logic vld_o
);

  assign vld_o = req0_i | req1_i;
  assign win_o = (req0_i & req1_i) ? ~last_i
               : (req1_i ? SEL_DM : SEL_IF);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and data (DM).
// One outstanding transaction, round-robin, with a stall watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              err,
  output logic              sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]        state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_gnt_q, if_gnt_d;
  logic              dm_gnt_q, dm_gnt_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;

  logic              win;
  logic              win_vld;
  logic              to_hit;
  logic [DATA_W-1:0] rd;

  rr_arb2 u_arb (
    .req0_i (if_req),
    .req1_i (dm_req),
    .last_i (last_q),
    .win_o  (win),
    .vld_o  (win_vld)
  );

  assign to_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = if_gnt_q;
    dm_gnt_d    = dm_gnt_q;
    if_done_d   = if_done_q;
    dm_done_d   = dm_done_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;
    rd          = mem_ack ? mem_rdata : '0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d     = ST_BUSY;
          sel_d       = win;
          mem_req_d   = 1'b1;
          mem_addr_d  = (win == SEL_DM) ? dm_addr : if_addr;
          mem_wdata_d = (win == SEL_DM) ? dm_wdata : '0;
          mem_we_d    = (win == SEL_DM) & dm_we;
          if_gnt_d    = (win == SEL_IF);
          dm_gnt_d    = (win == SEL_DM);
          cnt_d       = '0;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // Ack beats a coincident watchdog expiry.
        if (mem_ack || to_hit) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          last_d    = sel_q;
          err_d     = ~mem_ack;
          if_done_d = (sel_q == SEL_IF);
          dm_done_d = (sel_q == SEL_DM);
          if (sel_q == SEL_DM) dm_rdata_d = rd;
          else                 if_rdata_d = rd;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        if_done_d = 1'b0;
        dm_done_d = 1'b0;
        err_d     = 1'b0;
        if_gnt_d  = 1'b0;
        dm_gnt_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_IF;
      last_q      <= SEL_DM;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  assign sel       = sel_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Drivers, a memory responder and a monitor run side by side.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_done;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        err, sel, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(
    .DATA_W (32),
    .ADDR_W (32),
    .TIMEOUT(15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_gnt   (dm_gnt),
    .dm_done  (dm_done),
    .dm_rdata (dm_rdata),
    .err      (err),
    .sel      (sel),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } tx_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
    int          lat;
  } exp_t;

  tx_t         if_tx[$];
  tx_t         dm_tx[$];
  exp_t        exp_if[$];
  exp_t        exp_dm[$];
  logic        exp_own[$];
  logic [31:0] mem_img[logic [31:0]];
  int          ack_after;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic req_if(input logic [31:0] a, input int lat,
                        input logic to);
    tx_t  t;
    exp_t e;
    t.addr = a; t.we = 1'b0; t.wdata = '0;
    e.addr = a; e.we = 1'b0; e.wdata = '0;
    e.rdata  = to ? 32'h0 : mem_img[a];
    e.chk_rd = 1'b1;
    e.err    = to;
    e.lat    = lat;
    exp_if.push_back(e);
    if_tx.push_back(t);
  endtask

  task automatic req_dm(input logic [31:0] a, input logic we,
                        input logic [31:0] wd, input int lat,
                        input logic to);
    tx_t  t;
    exp_t e;
    t.addr = a; t.we = we; t.wdata = wd;
    e.addr = a; e.we = we; e.wdata = wd;
    e.rdata  = (to || !mem_img.exists(a)) ? 32'h0 : mem_img[a];
    e.chk_rd = !we;
    e.err    = to;
    e.lat    = lat;
    exp_dm.push_back(e);
    dm_tx.push_back(t);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_own.size() != 0 || if_tx.size() != 0 ||
                dm_tx.size() != 0 || mem_req || if_done ||
                dm_done) && n < budget);
    chk("phase_in_budget", n < budget, 1);
  endtask

  // Requesters hold req until done, then move to the next queued item.
  initial begin
    if_req = 1'b0; if_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (if_done && if_tx.size() != 0) void'(if_tx.pop_front());
      if (if_tx.size() != 0) begin
        if_req = 1'b1; if_addr = if_tx[0].addr;
      end else begin
        if_req = 1'b0;
      end
    end
  end

  initial begin
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (dm_done && dm_tx.size() != 0) void'(dm_tx.pop_front());
      if (dm_tx.size() != 0) begin
        dm_req   = 1'b1;
        dm_we    = dm_tx[0].we;
        dm_addr  = dm_tx[0].addr;
        dm_wdata = dm_tx[0].wdata;
      end else begin
        dm_req = 1'b0; dm_we = 1'b0;
      end
    end
  end

  // Memory: ack in BUSY cycle ack_after (0-based), junk data otherwise.
  initial begin
    int bc = 0;
    mem_ack = 1'b0; mem_rdata = 32'hBAD0_0000;
    forever begin
      @(posedge clk); #1;
      if (mem_req && !rst) begin
        if (bc == ack_after) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_img.exists(mem_addr) ? mem_img[mem_addr]
                                               : 32'h0;
          if (mem_we) mem_img[mem_addr] = mem_wdata;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'hBAD0_0000 | bc;
        end
        bc++;
      end else begin
        mem_ack = 1'b0; mem_rdata = 32'hBAD0_FFFF; bc = 0;
      end
    end
  end

  logic        prev_req, prev_ifd, prev_dmd, cap_sel, cap_we, own;
  logic [31:0] cap_addr, cap_wd;
  int          busy_n;
  exp_t        ce, de;

  initial begin
    prev_req = 0; prev_ifd = 0; prev_dmd = 0; busy_n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 0; prev_ifd = 0; prev_dmd = 0; busy_n = 0;
      end else begin
        if (mem_req && !prev_req) begin
          chk("issue_expected", exp_own.size() != 0, 1);
          if (exp_own.size() != 0) begin
            own = exp_own.pop_front();
            chk("sel", sel, own);
            chk("gnt", {if_gnt, dm_gnt}, own ? 2'b01 : 2'b10);
            if (own) chk("dm_exp_avail", exp_dm.size() != 0, 1);
            else     chk("if_exp_avail", exp_if.size() != 0, 1);
            if (own ? exp_dm.size() != 0 : exp_if.size() != 0) begin
              ce = own ? exp_dm[0] : exp_if[0];
              chk("mem_addr", mem_addr, ce.addr);
              chk("mem_we", mem_we, ce.we);
              chk("mem_wdata", mem_wdata, ce.wdata);
            end
          end
          cap_sel = sel; cap_we = mem_we;
          cap_addr = mem_addr; cap_wd = mem_wdata;
          busy_n = 1;
        end else if (mem_req) begin
          chk("hold", {sel, mem_we, mem_wdata},
              {cap_sel, cap_we, cap_wd});
          chk("hold_addr", mem_addr, cap_addr);
          busy_n++;
        end
        if (if_done | dm_done)
          chk("one_done", if_done & dm_done, 0);
        if (prev_ifd) chk("if_done_pulse", if_done, 0);
        if (prev_dmd) chk("dm_done_pulse", dm_done, 0);
        if (if_done) begin
          chk("if_done_expected", exp_if.size() != 0, 1);
          if (exp_if.size() != 0) begin
            de = exp_if.pop_front();
            if (de.chk_rd) chk("if_rdata", if_rdata, de.rdata);
            chk("if_err", err, de.err);
            chk("if_lat", busy_n, de.lat);
            chk("if_gnt_done", if_gnt, 1);
            chk("mem_req_done", mem_req, 0);
          end
        end
        if (dm_done) begin
          chk("dm_done_expected", exp_dm.size() != 0, 1);
          if (exp_dm.size() != 0) begin
            de = exp_dm.pop_front();
            if (de.chk_rd) chk("dm_rdata", dm_rdata, de.rdata);
            chk("dm_err", err, de.err);
            chk("dm_lat", busy_n, de.lat);
            chk("dm_gnt_done", dm_gnt, 1);
            chk("mem_req_done", mem_req, 0);
          end
        end
        prev_req = mem_req; prev_ifd = if_done; prev_dmd = dm_done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1;
    ack_after = 1;
    mem_img[32'h0000_0040] = 32'h0010_0093;
    mem_img[32'h0000_0044] = 32'h0020_0113;
    mem_img[32'h0000_0048] = 32'h0030_0193;
    mem_img[32'h0000_0080] = 32'h00A0_0513;
    mem_img[32'h0000_2000] = 32'hCAFE_F00D;
    mem_img[32'h0000_2004] = 32'h1234_5678;
    repeat (2) @(negedge clk);
    chk("rst_mem", {mem_req, mem_we, sel}, 0);
    chk("rst_gnt", {if_gnt, dm_gnt}, 0);
    chk("rst_done", {if_done, dm_done, err}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 0);
    rst = 1'b0;

    // single fetch, ack in the 2nd BUSY cycle
    @(negedge clk);
    ack_after = 1;
    exp_own.push_back(1'b0);
    req_if(32'h40, 2, 1'b0);
    wait_idle(50);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // both requesting after reset: IF, DM, IF, DM
    ack_after = 1;
    exp_own.push_back(1'b0); exp_own.push_back(1'b1);
    exp_own.push_back(1'b0); exp_own.push_back(1'b1);
    req_if(32'h44, 2, 1'b0);
    req_dm(32'h2000, 1'b0, 32'h0, 2, 1'b0);
    req_if(32'h48, 2, 1'b0);
    req_dm(32'h2004, 1'b0, 32'h0, 2, 1'b0);
    wait_idle(100);

    // store with immediate ack
    ack_after = 0;
    exp_own.push_back(1'b1);
    req_dm(32'h1000, 1'b1, 32'hDEAD_BEEF, 1, 1'b0);
    wait_idle(50);

    // watchdog abort of a load
    ack_after = 1000;
    exp_own.push_back(1'b1);
    req_dm(32'h2000, 1'b0, 32'h0, 15, 1'b1);
    wait_idle(100);

    // ack on the last watchdog cycle
    ack_after = 14;
    exp_own.push_back(1'b0);
    req_if(32'h80, 15, 1'b0);
    wait_idle(100);

    // reset in the middle of a stalled DM load
    ack_after = 1000;
    exp_own.push_back(1'b1);
    req_dm(32'h2004, 1'b0, 32'h0, 15, 1'b1);
    repeat (4) @(negedge clk);
    chk("mid_busy_req", {mem_req, dm_gnt, sel}, 3'b111);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_gnt", {if_gnt, dm_gnt}, 0);
    chk("arst_sel", sel, 0);
    chk("arst_done", {if_done, dm_done, err}, 0);
    exp_own.delete(); exp_dm.delete(); dm_tx.delete();
    @(negedge clk);
    chk("no_done_in_rst", {if_done, dm_done}, 0);
    ack_after = 1;
    exp_own.push_back(1'b0); exp_own.push_back(1'b1);
    req_if(32'h40, 2, 1'b0);
    req_dm(32'h2000, 1'b0, 32'h0, 2, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
